// File: rtl/axi_stream_pkt_arbiter_2to1_if.sv
// Signal bundle for the 2:1 packet arbiter: two input streams, one output stream,
// grant status and the optional per-port packet counters.
interface axi_stream_pkt_arbiter_2to1_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] tdata_0;
    logic              tvalid_0;
    logic              tlast_0;
    logic              tready_0;
    logic [DATA_W-1:0] tdata_1;
    logic              tvalid_1;
    logic              tlast_1;
    logic              tready_1;
    logic [DATA_W-1:0] tdata_out;
    logic              tvalid_out;
    logic              tlast_out;
    logic              tready_out;
    logic              sel;
    logic              busy;
    logic [CNT_W-1:0]  pkt_cnt_0;
    logic [CNT_W-1:0]  pkt_cnt_1;

    // Handshake: a beat moves on any rising edge where tvalid and tready are both 1;
    // a source holds tvalid and its payload stable until that happens.
    modport slave (
        input  tdata_0, tvalid_0, tlast_0,
        output tready_0,
        input  tdata_1, tvalid_1, tlast_1,
        output tready_1,
        output tdata_out, tvalid_out, tlast_out,
        input  tready_out,
        output sel, busy, pkt_cnt_0, pkt_cnt_1
    );

    modport master (
        output tdata_0, tvalid_0, tlast_0,
        input  tready_0,
        output tdata_1, tvalid_1, tlast_1,
        input  tready_1,
        input  tdata_out, tvalid_out, tlast_out,
        output tready_out,
        input  sel, busy, pkt_cnt_0, pkt_cnt_1
    );
endinterface

// File: rtl/axi_stream_pkt_arbiter_2to1.sv
// Packet-aware round-robin 2:1 AXI-Stream arbiter; grant is held until the tlast beat.
// Optional per-port saturating packet counters are enabled by defining AXIS_ARB_PKT_CNT_EN.
module axi_stream_pkt_arbiter_2to1 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst,
    axi_stream_pkt_arbiter_2to1_if.slave s
);
    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t            state, state_nxt;
    logic              sel_q, sel_nxt;
    logic              last_grant, last_grant_nxt;
    logic [DATA_W-1:0] data_mux;
    logic              valid_mux, last_mux;
    logic              rdy_0, rdy_1;
    logic              busy_c;
    logic              beat_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_q      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            sel_q      <= sel_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel_q;
        last_grant_nxt = last_grant;
        data_mux       = '0;
        valid_mux      = 1'b0;
        last_mux       = 1'b0;
        rdy_0          = 1'b0;
        rdy_1          = 1'b0;
        busy_c         = 1'b0;
        beat_done      = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (s.tvalid_0 || s.tvalid_1) begin
                        // On a tie the port that did not win last time gets the grant.
                        if (s.tvalid_0 && s.tvalid_1) sel_nxt = ~last_grant;
                        else                          sel_nxt = s.tvalid_1;
                        last_grant_nxt = sel_nxt;
                        state_nxt      = LOCK;
                    end
                end
                LOCK: begin
                    busy_c    = 1'b1;
                    data_mux  = sel_q ? s.tdata_1  : s.tdata_0;
                    valid_mux = sel_q ? s.tvalid_1 : s.tvalid_0;
                    last_mux  = sel_q ? s.tlast_1  : s.tlast_0;
                    rdy_0     = !sel_q && s.tready_out;
                    rdy_1     = sel_q && s.tready_out;
                    beat_done = valid_mux && s.tready_out && last_mux;
                    if (beat_done) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign s.tdata_out  = data_mux;
    assign s.tvalid_out = valid_mux;
    assign s.tlast_out  = last_mux;
    assign s.tready_0   = rdy_0;
    assign s.tready_1   = rdy_1;
    assign s.sel        = sel_q;
    assign s.busy       = busy_c;

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [CNT_W-1:0] cnt_0, cnt_1;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_0 <= '0;
            cnt_1 <= '0;
        end else if (beat_done) begin
            if (!sel_q && (cnt_0 != '1)) cnt_0 <= cnt_0 + CNT_W'(1);
            if (sel_q && (cnt_1 != '1))  cnt_1 <= cnt_1 + CNT_W'(1);
        end
    end

    assign s.pkt_cnt_0 = cnt_0;
    assign s.pkt_cnt_1 = cnt_1;
`else
    assign s.pkt_cnt_0 = {CNT_W{1'b0}};
    assign s.pkt_cnt_1 = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_axi_stream_pkt_arbiter_2to1.sv
// Bench for the 2:1 packet arbiter: queue-fed sources, scoreboard on accepted output beats.
// Build with AXIS_ARB_PKT_CNT_EN defined to exercise the counters at CNT_W = 2.
`timescale 1ns/1ps
module tb_axi_stream_pkt_arbiter_2to1;
  localparam int DATA_W = 32;
`ifdef AXIS_ARB_PKT_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif
  localparam int SB_W = DATA_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_stream_pkt_arbiter_2to1_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) axis ();

  axi_stream_pkt_arbiter_2to1 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .s   (axis)
  );

  int total = 0;
  int bad   = 0;

  logic [DATA_W:0]   src0_q[$];
  logic [DATA_W:0]   src1_q[$];
  logic [SB_W-1:0]   exp_q[$];
  logic              acc0 = 1'b0;
  logic              acc1 = 1'b0;
  logic [SB_W-1:0]   mon_got;
  logic [SB_W-1:0]   mon_exp;

  // ---------------- source drivers ----------------
  initial begin
    axis.tvalid_0 = 1'b0; axis.tlast_0 = 1'b0; axis.tdata_0 = '0;
    axis.tvalid_1 = 1'b0; axis.tlast_1 = 1'b0; axis.tdata_1 = '0;
    forever begin
      @(posedge clk); #1;
      if (acc0 && src0_q.size() > 0) void'(src0_q.pop_front());
      if (acc1 && src1_q.size() > 0) void'(src1_q.pop_front());
      if (src0_q.size() > 0) begin
        axis.tvalid_0 = 1'b1; {axis.tlast_0, axis.tdata_0} = src0_q[0];
      end else begin
        axis.tvalid_0 = 1'b0; axis.tlast_0 = 1'b0; axis.tdata_0 = '0;
      end
      if (src1_q.size() > 0) begin
        axis.tvalid_1 = 1'b1; {axis.tlast_1, axis.tdata_1} = src1_q[0];
      end else begin
        axis.tvalid_1 = 1'b0; axis.tlast_1 = 1'b0; axis.tdata_1 = '0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    acc0 = axis.tvalid_0 && axis.tready_0;
    acc1 = axis.tvalid_1 && axis.tready_1;
    if (axis.busy === 1'b1) begin
      total++;
      if ((axis.sel ? axis.tready_0 : axis.tready_1) !== 1'b0) begin
        bad++;
        $display("FAIL ungranted_ready: got=1 exp=0 (sel=%b) t=%0t", axis.sel, $time);
      end
    end
    if (axis.tvalid_out && axis.tready_out) begin
      mon_got = {axis.sel, axis.tlast_out, axis.tdata_out};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: got=%h exp=none t=%0t", mon_got, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL beat {sel,last,data}: got=%h exp=%h t=%0t", mon_got, mon_exp, $time);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push_pkt(input logic port, input logic [DATA_W-1:0] base, input int beats);
    logic lst;
    for (int i = 0; i < beats; i++) begin
      lst = (i == beats - 1);
      if (port) src1_q.push_back({lst, base + DATA_W'(i)});
      else      src0_q.push_back({lst, base + DATA_W'(i)});
      exp_q.push_back({port, lst, base + DATA_W'(i)});
    end
  endtask

  task automatic drain(output int remaining);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    remaining = exp_q.size();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int rem;
    push_pkt(1'b0, 32'hF0, 1);
    push_pkt(1'b1, 32'hF8, 1);
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (axis.tvalid_out !== 1'b0) begin bad++; $display("FAIL rst_tvalid_out: got=%b exp=0", axis.tvalid_out); end
      total++; if (axis.tready_0 !== 1'b0) begin bad++; $display("FAIL rst_tready_0: got=%b exp=0", axis.tready_0); end
      total++; if (axis.tready_1 !== 1'b0) begin bad++; $display("FAIL rst_tready_1: got=%b exp=0", axis.tready_1); end
      total++; if (axis.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b exp=0", axis.busy); end
      total++; if (axis.tlast_out !== 1'b0) begin bad++; $display("FAIL rst_tlast_out: got=%b exp=0", axis.tlast_out); end
      total++; if (axis.tdata_out !== '0) begin bad++; $display("FAIL rst_tdata_out: got=%h exp=0", axis.tdata_out); end
    end
    total++; if (axis.sel !== 1'b0) begin bad++; $display("FAIL rst_sel: got=%b exp=0", axis.sel); end
    total++; if (axis.pkt_cnt_0 !== '0) begin bad++; $display("FAIL rst_pkt_cnt_0: got=%0d exp=0", axis.pkt_cnt_0); end
    rst = 1'b0;
    drain(rem);
    total++; if (rem !== 0) begin bad++; $display("FAIL reset_tie_drain: got=%0d left exp=0", rem); end
  endtask

  task automatic test_single_port();
    int rem;
    apply_reset();
    push_pkt(1'b0, 32'hA0, 3);
    tick();
    total++; if (axis.tvalid_out !== 1'b0) begin bad++; $display("FAIL latency_early: got=%b exp=0", axis.tvalid_out); end
    tick();
    total++; if (axis.tvalid_out !== 1'b1) begin bad++; $display("FAIL latency_valid: got=%b exp=1", axis.tvalid_out); end
    total++; if (axis.tdata_out !== 32'hA0) begin bad++; $display("FAIL first_data: got=%h exp=a0", axis.tdata_out); end
    total++; if (axis.busy !== 1'b1) begin bad++; $display("FAIL lock_busy: got=%b exp=1", axis.busy); end
    total++; if (axis.sel !== 1'b0) begin bad++; $display("FAIL lock_sel: got=%b exp=0", axis.sel); end
    drain(rem);
    total++; if (rem !== 0) begin bad++; $display("FAIL single_drain: got=%0d left exp=0", rem); end
    total++; if (axis.busy !== 1'b0) begin bad++; $display("FAIL post_pkt_busy: got=%b exp=0", axis.busy); end
  endtask

  task automatic test_round_robin();
    int idle, n;
    bit seen;
    apply_reset();
    push_pkt(1'b0, 32'h100, 2);
    push_pkt(1'b1, 32'h200, 2);
    push_pkt(1'b0, 32'h110, 2);
    push_pkt(1'b1, 32'h210, 2);
    idle = 0; n = 0; seen = 1'b0;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
      if (exp_q.size() == 0) break;
      if (axis.busy) seen = 1'b1;
      else if (seen) idle++;
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rr_drain: got=%0d left exp=0", exp_q.size()); end
    total++; if (idle !== 3) begin bad++; $display("FAIL rr_bubbles: got=%0d exp=3", idle); end
  endtask

  task automatic test_backpressure();
    int n, rem;
    apply_reset();
    push_pkt(1'b1, 32'hB0, 3);
    n = 0;
    while (axis.busy !== 1'b1 && n < 10) begin tick(); n++; end
    total++; if (axis.busy !== 1'b1) begin bad++; $display("FAIL bp_lock_timeout: got=%b exp=1", axis.busy); end
    total++; if (axis.sel !== 1'b1) begin bad++; $display("FAIL bp_sel: got=%b exp=1", axis.sel); end
    push_pkt(1'b0, 32'hC0, 1);
    tick();
    axis.tready_out = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (axis.tvalid_0 !== 1'b1) begin bad++; $display("FAIL bp_src0_valid: got=%b exp=1", axis.tvalid_0); end
      total++; if (axis.tready_0 !== 1'b0) begin bad++; $display("FAIL bp_tready_0: got=%b exp=0", axis.tready_0); end
      total++; if (axis.sel !== 1'b1) begin bad++; $display("FAIL bp_sel_hold: got=%b exp=1", axis.sel); end
      total++; if (axis.tvalid_out !== 1'b1) begin bad++; $display("FAIL bp_valid_hold: got=%b exp=1", axis.tvalid_out); end
      total++; if (axis.tdata_out !== 32'hB1) begin bad++; $display("FAIL bp_data_hold: got=%h exp=b1", axis.tdata_out); end
    end
    axis.tready_out = 1'b1;
    drain(rem);
    total++; if (rem !== 0) begin bad++; $display("FAIL bp_drain: got=%0d left exp=0", rem); end
  endtask

  task automatic test_reset_mid_packet();
    int n, rem;
    apply_reset();
    push_pkt(1'b0, 32'hD0, 4);
    n = 0;
    while (!(axis.busy === 1'b1 && axis.tdata_out === 32'hD1) && n < 20) begin tick(); n++; end
    total++; if (axis.tdata_out !== 32'hD1) begin bad++; $display("FAIL mid_reach_beat2: got=%h exp=d1", axis.tdata_out); end
    rst = 1'b1;
    #1;
    total++; if (axis.tvalid_out !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got=%b exp=0", axis.tvalid_out); end
    total++; if (axis.tready_0 !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got=%b exp=0", axis.tready_0); end
    tick();
    src0_q.delete();
    exp_q.delete();
    tick();
    rst = 1'b0;
    #1;
    total++; if (axis.busy !== 1'b0) begin bad++; $display("FAIL mid_idle_after_rst: got=%b exp=0", axis.busy); end
    total++; if (axis.sel !== 1'b0) begin bad++; $display("FAIL mid_sel_after_rst: got=%b exp=0", axis.sel); end
    push_pkt(1'b0, 32'hE0, 1);
    push_pkt(1'b1, 32'hE8, 1);
    drain(rem);
    total++; if (rem !== 0) begin bad++; $display("FAIL mid_rearb_drain: got=%0d left exp=0", rem); end
  endtask

  task automatic test_pkt_counters();
    int rem;
    logic [CNT_W-1:0] exp_c0;
    apply_reset();
    for (int p = 0; p < 5; p++) push_pkt(1'b0, 32'h300 + DATA_W'(p), 1);
    drain(rem);
    tick();
    total++; if (rem !== 0) begin bad++; $display("FAIL cnt_drain: got=%0d left exp=0", rem); end
`ifdef AXIS_ARB_PKT_CNT_EN
    exp_c0 = '1;
`else
    exp_c0 = '0;
`endif
    total++; if (axis.pkt_cnt_0 !== exp_c0) begin bad++; $display("FAIL pkt_cnt_0: got=%0d exp=%0d", axis.pkt_cnt_0, exp_c0); end
    total++; if (axis.pkt_cnt_1 !== '0) begin bad++; $display("FAIL pkt_cnt_1: got=%0d exp=0", axis.pkt_cnt_1); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1;
    axis.tready_out = 1'b1;
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_reset_mid_packet();
    test_pkt_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
